// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared types for the AXI4-Lite to mem_* bridge.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4lite_mem_bridge.sv
// axi4lite_mem_bridge: AXI4-Lite slave front end driving the single-cycle
// mem_* select/strobe interface of the register demux stage.
// Independent write and read FSMs, one outstanding transaction per channel.
// Build option: define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order, or both in one cycle)
// W_EXEC | one cycle of mem_wrSelect / byte strobes
// W_RESP | BVALID held until BREADY
// R_IDLE | waiting for AR
// R_EXEC | one cycle of mem_rdSelect / mem_rdStrobe, mem_rddout captured
// R_RESP | RVALID held with stable RDATA until RREADY
module axi4lite_mem_bridge
    import axi4lite_pkg::*;
#(
    parameter int REGISTER_N     = 16,
    parameter int REG_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [REG_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [REG_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [REG_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          mem_wrSelect,
    output logic [$clog2(REGISTER_N)-1:0] mem_wrAddr,
    output logic [REG_DATA_WIDTH-1:0]     mem_wrdin,
    output logic [REG_DATA_WIDTH/8-1:0]   mem_wrByteStrobe,
    output logic                          mem_rdSelect,
    output logic                          mem_rdStrobe,
    output logic [$clog2(REGISTER_N)-1:0] mem_rdAddr,
    input  logic [REG_DATA_WIDTH-1:0]     mem_rddout
);

    localparam int ADDR_LSB = $clog2(REG_DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(REGISTER_N);
    localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = REG_DATA_WIDTH / 8;
    localparam logic [WORD_W:0] REG_LIMIT = (WORD_W + 1)'(REGISTER_N);

`ifdef AXIL_SLVERR_EN
    localparam axi_resp_t ERR_RESP = SLVERR;
`else
    localparam axi_resp_t ERR_RESP = OKAY;
`endif

    // Full word address is compared, so any set bit above the decoded index
    // makes the access out of range.
    function automatic logic in_range(input logic [WORD_W-1:0] word);
        return {1'b0, word} < REG_LIMIT;
    endfunction

    wr_state_t                 wr_state_q, wr_state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic [WORD_W-1:0]         awword_q;
    logic [REG_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    axi_resp_t                 bresp_q;

    rd_state_t                 rd_state_q, rd_state_d;
    logic                      arready_q, arready_d;
    logic [WORD_W-1:0]         arword_q;
    logic [REG_DATA_WIDTH-1:0] rdata_q;
    axi_resp_t                 rresp_q;

    logic aw_hs, w_hs, ar_hs;
    logic wr_in_range, rd_in_range;
    logic unused_ok;

    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign ar_hs       = S_AXI_ARVALID && arready_q;
    assign wr_in_range = in_range(awword_q);
    assign rd_in_range = in_range(arword_q);
    assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Write channel next state; readies are registered from the next state so
    // they drop the cycle after their beat is taken and are low in reset.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_EXEC;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_EXEC:  wr_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
        awready_d = (wr_state_d == W_IDLE) && !aw_done_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_done_d;
    end

    // Write channel registers: state, captured beats and response code.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            awword_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            if (aw_hs) awword_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_state_q == W_EXEC) bresp_q <= wr_in_range ? OKAY : ERR_RESP;
        end
    end

    // Read channel next state.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_EXEC;
            R_EXEC:  rd_state_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    // Read channel registers; RDATA is captured once in R_EXEC and held.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            arword_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            if (ar_hs) arword_q <= S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
            if (rd_state_q == R_EXEC) begin
                rdata_q <= rd_in_range ? mem_rddout : '0;
                rresp_q <= rd_in_range ? OKAY : ERR_RESP;
            end
        end
    end

    assign S_AXI_AWREADY    = awready_q;
    assign S_AXI_WREADY     = wready_q;
    assign S_AXI_BVALID     = (wr_state_q == W_RESP);
    assign S_AXI_BRESP      = bresp_q;
    assign S_AXI_ARREADY    = arready_q;
    assign S_AXI_RVALID     = (rd_state_q == R_RESP);
    assign S_AXI_RDATA      = rdata_q;
    assign S_AXI_RRESP      = rresp_q;

    assign mem_wrSelect     = (wr_state_q == W_EXEC) && wr_in_range;
    assign mem_wrByteStrobe = mem_wrSelect ? wstrb_q : '0;
    assign mem_wrAddr       = awword_q[IDX_W-1:0];
    assign mem_wrdin        = wdata_q;
    assign mem_rdSelect     = (rd_state_q == R_EXEC) && rd_in_range;
    assign mem_rdStrobe     = mem_rdSelect;
    assign mem_rdAddr       = arword_q[IDX_W-1:0];

endmodule
